// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg -- shared types and constants for the 32-bit word UART transmitter.
//   state_t    : transmit FSM states (PARITY only reachable with parity build)
//   DATA_BITS  : data bits per UART frame
//   FRAME_BITS : start + data (+ parity) + stop
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit).
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // States during which a bit period is on the line.
  function automatic logic is_busy(input state_t s);
    return (s == START) || (s == DATA) || (s == PARITY) || (s == STOP);
  endfunction

endpackage

// File: rtl/uart_tx_word32_if.sv
// ---------------------------------------------------------------------------
// uart_tx_word32_if -- request/status bundle of the word transmitter.
//   start     : transmit request (rising edge acts)
//   data      : word to send, 8*NUM_BYTES bits
//   tx_out    : serial line, idles high
//   busy      : word in flight
//   tx_done   : one-cycle completion pulse
//   baud_tick : one-cycle pulse at every bit boundary
// master = requester side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_word32_if #(
  parameter int NUM_BYTES = 4
);
  logic                   start;
  logic [8*NUM_BYTES-1:0] data;
  logic                   tx_out;
  logic                   busy;
  logic                   tx_done;
  logic                   baud_tick;

  modport master (output start, data, input tx_out, busy, tx_done, baud_tick);
  modport slave  (input start, data, output tx_out, busy, tx_done, baud_tick);
endinterface

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen -- bit-period counter.
//   clk   : system clock
//   rst_n : synchronous reset, active low
//   run   : count enable; counter held at 0 while low
//   tick  : high in the last cycle of each bit period (count == CLKS_PER_BIT-1)
// ---------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  assign tick = run && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || !run) r_cnt <= '0;
    else if (tick)      r_cnt <= '0;
    else                r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx_word32.sv
// ---------------------------------------------------------------------------
// uart_tx_word32 -- sends one 8*NUM_BYTES-bit word as NUM_BYTES back-to-back
// UART frames, byte 0 (data[7:0]) first, LSB first within each byte.
//   clk   : system clock, rising edge
//   rst_n : synchronous reset, active low; drops any word in flight
//   tx_if : slave modport -- start/data in; tx_out/busy/tx_done/baud_tick out
// Optional feature macro: UART_TX_PARITY_EN -- inserts an even-parity bit
// between the data bits and the stop bit (11-bit frame).
// Line and status outputs are registered from the next-state decode so the
// pin never sees combinational glitches.
// ---------------------------------------------------------------------------
module uart_tx_word32
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int NUM_BYTES    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_word32_if.slave    tx_if
);
  localparam int W   = DATA_BITS * NUM_BYTES;
  localparam int BYW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int BIW = $clog2(DATA_BITS);
  localparam logic [BIW-1:0] LAST_BIT  = BIW'(DATA_BITS - 1);
  localparam logic [BYW-1:0] LAST_BYTE = BYW'(NUM_BYTES - 1);

  state_t         r_state, w_state_nxt;
  logic           r_start_q;
  logic [W-1:0]   r_shift, w_shift_nxt;
  logic [BIW-1:0] r_bit_idx, w_bit_idx_nxt;
  logic [BYW-1:0] r_byte_idx, w_byte_idx_nxt;
  logic           r_tx_out, r_busy, r_tx_done;
  logic           w_tx_nxt;
  logic           w_tick, w_accept;
`ifdef UART_TX_PARITY_EN
  logic           r_par, w_par_nxt;
`endif

  // r_busy mirrors is_busy(r_state), so it doubles as the baud enable.
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (r_busy),
    .tick (w_tick)
  );

  assign w_accept = (r_state == IDLE) && tx_if.start && !r_start_q;

  assign tx_if.tx_out    = r_tx_out;
  assign tx_if.busy      = r_busy;
  assign tx_if.tx_done   = r_tx_done;
  assign tx_if.baud_tick = w_tick;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_start_q  <= 1'b0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_tx_out   <= 1'b1;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_start_q  <= tx_if.start;
      r_shift    <= w_shift_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_tx_out   <= w_tx_nxt;
      r_busy     <= is_busy(w_state_nxt);
      r_tx_done  <= (w_state_nxt == DONE);
`ifdef UART_TX_PARITY_EN
      r_par      <= w_par_nxt;
`endif
    end
  end

  // Next-state / datapath
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_idx_nxt  = r_bit_idx;
    w_byte_idx_nxt = r_byte_idx;
`ifdef UART_TX_PARITY_EN
    w_par_nxt      = r_par;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt    = START;
          w_shift_nxt    = tx_if.data;
          w_bit_idx_nxt  = '0;
          w_byte_idx_nxt = '0;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt   = DATA;
          w_bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
          w_par_nxt     = 1'b0;
`endif
        end
      end
      DATA: begin
        if (w_tick) begin
          // Whole word shifts right, so after 8 bits the next byte sits in [7:0].
          w_shift_nxt = r_shift >> 1;
`ifdef UART_TX_PARITY_EN
          w_par_nxt   = r_par ^ r_shift[0];
`endif
          if (r_bit_idx == LAST_BIT) begin
            w_bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt   = PARITY;
`else
            w_state_nxt   = STOP;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_tick) w_state_nxt = STOP;
      end
`endif
      STOP: begin
        if (w_tick) begin
          if (r_byte_idx < LAST_BYTE) begin
            w_byte_idx_nxt = r_byte_idx + 1'b1;
            w_state_nxt    = START;
          end else begin
            w_byte_idx_nxt = '0;
            w_state_nxt    = DONE;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode of the state being entered; registered above.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_nxt = w_par_nxt;
`endif
      default: w_tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_word32.sv
module tb_uart_tx_word32;
  import uart_pkg::*;

  localparam int C        = 4;
  localparam int NB       = 4;
  localparam int WORD_CYC = NB * FRAME_BITS * C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_word32_if #(.NUM_BYTES(NB)) tx_if ();

  uart_tx_word32 #(.CLKS_PER_BIT(C), .NUM_BYTES(NB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .tx_if(tx_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- line monitor / behavioural receiver ----------------
  logic [7:0] rx_q[$];
  logic       par_q[$];
  logic [7:0] rx_byte;
  logic       rx_act = 1'b0;
  logic       prev_busy = 1'b0;
  int rx_cnt = 0, cur_len = 0, last_len = 0, periods = 0, done_cnt = 0;
  int tick_cnt = 0, tick_bad = 0, frame_err = 0, fall_bad = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_act  = 1'b0;
      cur_len = 0;
      prev_busy = 1'b0;
    end else begin
      if (tx_if.busy) cur_len++;
      if (prev_busy && !tx_if.busy) begin
        last_len = cur_len;
        cur_len  = 0;
        periods++;
        if (!tx_if.tx_done) fall_bad++;
      end
      if (tx_if.tx_done) done_cnt++;
      if (tx_if.baud_tick) begin
        tick_cnt++;
        if (!tx_if.busy) tick_bad++;
      end
      if (!rx_act) begin
        if (tx_if.tx_out == 1'b0) begin
          rx_act = 1'b1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % C == C / 2) begin
          automatic int k = rx_cnt / C;
          if (k == 0) begin
            if (tx_if.tx_out !== 1'b0) frame_err++;
          end else if (k <= 8) begin
            rx_byte[k-1] = tx_if.tx_out;
          end else if (k == FRAME_BITS - 1) begin
            if (tx_if.tx_out !== 1'b1) frame_err++;
            rx_q.push_back(rx_byte);
            rx_act = 1'b0;
          end else begin
            par_q.push_back(tx_if.tx_out);
          end
        end
      end
      prev_busy = tx_if.busy;
    end
  end

  // ---------------- helpers ----------------
  int b_periods, b_done, b_ticks, b_ferr, b_fall, b_tbad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic snap();
    b_periods = periods; b_done = done_cnt; b_ticks = tick_cnt;
    b_ferr = frame_err; b_fall = fall_bad; b_tbad = tick_bad;
    rx_q.delete(); par_q.delete();
  endtask

  task automatic pulse(input logic [31:0] w);
    tx_if.data = w; tx_if.start = 1'b1;
    cyc(1);
    tx_if.start = 1'b0;
  endtask

  // Returns #1 into the tx_done cycle.
  task automatic wait_done(input string tag);
    int n = 0;
    while (!tx_if.tx_done && n < WORD_CYC + 50) begin cyc(1); n++; end
    chk({tag, "_done_seen"}, 32'(tx_if.tx_done), 32'd1);
  endtask

  // Compares everything the monitor gathered since snap() against the word.
  task automatic check_word(input string tag, input logic [31:0] w);
    chk({tag, "_periods"}, 32'(periods - b_periods), 32'd1);
    chk({tag, "_done_pulses"}, 32'(done_cnt - b_done), 32'd1);
    chk({tag, "_busy_len"}, 32'(last_len), 32'(WORD_CYC));
    chk({tag, "_ticks"}, 32'(tick_cnt - b_ticks), 32'(NB * FRAME_BITS));
    chk({tag, "_tick_idle"}, 32'(tick_bad - b_tbad), 32'd0);
    chk({tag, "_framing"}, 32'(frame_err - b_ferr), 32'd0);
    chk({tag, "_done_at_fall"}, 32'(fall_bad - b_fall), 32'd0);
    chk({tag, "_nbytes"}, 32'(rx_q.size()), 32'(NB));
    for (int i = 0; i < NB && i < rx_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'((w >> (8 * i)) & 32'hFF));
`ifdef UART_TX_PARITY_EN
    chk({tag, "_npar"}, 32'(par_q.size()), 32'(NB));
    for (int i = 0; i < NB && i < par_q.size(); i++)
      chk($sformatf("%s_par%0d", tag, i), 32'(par_q[i]), 32'(^((w >> (8 * i)) & 32'hFF)));
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] w, w2;
    tx_if.start = 1'b0;
    tx_if.data  = '0;

    // Reset
    cyc(3);
    chk("rst_tx_out", 32'(tx_if.tx_out), 32'd1);
    chk("rst_busy", 32'(tx_if.busy), 32'd0);
    chk("rst_tx_done", 32'(tx_if.tx_done), 32'd0);
    chk("rst_baud_tick", 32'(tx_if.baud_tick), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Basic word, with busy/tx_out checked on the edge after acceptance
    snap();
    pulse(32'hA5C30F81);
    chk("basic_accept_busy", 32'(tx_if.busy), 32'd1);
    chk("basic_start_bit", 32'(tx_if.tx_out), 32'd0);
    wait_done("basic");
    cyc(1);
    check_word("basic", 32'hA5C30F81);
    chk("basic_idle_line", 32'(tx_if.tx_out), 32'd1);

    // Random words with random gaps
    for (int r = 0; r < 3; r++) begin
      w = $urandom();
      cyc($urandom_range(1, 9));
      snap();
      pulse(w);
      wait_done("rand");
      cyc(1);
      check_word($sformatf("rand%0d", r), w);
    end

    // Parity pattern (plain build still checks the bytes)
    cyc(3);
    snap();
    pulse(32'h00000007);
    wait_done("par7");
    cyc(1);
    check_word("par7", 32'h00000007);

    // Level start: held high 500 cycles, exactly one word
    cyc(3);
    w = $urandom();
    snap();
    tx_if.data = w; tx_if.start = 1'b1;
    cyc(500);
    tx_if.start = 1'b0;
    cyc(20);
    check_word("level", w);

    // Start edge while busy at cycle 50; data changes must not leak in
    cyc(3);
    w = $urandom();
    snap();
    pulse(w);
    cyc(49);
    tx_if.data = 32'hFFFFFFFF; tx_if.start = 1'b1;
    cyc(1);
    tx_if.start = 1'b0;
    wait_done("busy_start");
    cyc(1);
    check_word("busy_start", w);
    cyc(WORD_CYC + 40);
    chk("busy_start_no_queue", 32'(periods - b_periods), 32'd1);

    // Reset mid-word
    cyc(3);
    snap();
    pulse($urandom());
    cyc(36);
    rst_n = 1'b0;
    cyc(1);
    chk("midrst_tx_out", 32'(tx_if.tx_out), 32'd1);
    chk("midrst_busy", 32'(tx_if.busy), 32'd0);
    chk("midrst_tx_done", 32'(tx_if.tx_done), 32'd0);
    rst_n = 1'b1;
    cyc(2);
    chk("midrst_no_done", 32'(done_cnt - b_done), 32'd0);
    w = $urandom();
    snap();
    pulse(w);
    wait_done("after_rst");
    cyc(1);
    check_word("after_rst", w);

    // Back-to-back: start edge in the cycle after tx_done
    cyc(3);
    w = $urandom(); w2 = $urandom();
    snap();
    pulse(w);
    wait_done("b2b1");
    cyc(1);
    tx_if.data = w2; tx_if.start = 1'b1;
    check_word("b2b1", w);
    chk("b2b_idle_cycle_busy", 32'(tx_if.busy), 32'd0);
    snap();
    cyc(1);
    tx_if.start = 1'b0;
    chk("b2b_accept_busy", 32'(tx_if.busy), 32'd1);
    chk("b2b_start_bit", 32'(tx_if.tx_out), 32'd0);
    wait_done("b2b2");
    cyc(1);
    check_word("b2b2", w2);

    // Start edge coinciding with tx_done is ignored
    cyc(3);
    w = $urandom();
    snap();
    pulse(w);
    wait_done("done_edge");
    tx_if.start = 1'b1;
    cyc(1);
    check_word("done_edge", w);
    cyc(30);
    chk("done_edge_ignored_busy", 32'(tx_if.busy), 32'd0);
    chk("done_edge_ignored_periods", 32'(periods - b_periods), 32'd1);
    tx_if.start = 1'b0;
    cyc(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
